phy_tx_lane_serializer: RTL

- Transmit-side stage that produces the two serial lanes (Data_out_0, Data_out_1) consumed by the phy_rx receivers.
- Accepts 32-bit words through a valid/ready handshake, byte-stripes each word across two lanes and serializes MSB-first at clk_32f.
- When no word is available, transmits comma/idle symbol 0xBC on both lanes so the receiver can keep byte alignment.

---
 rtl/phy_tx_lane_serializer.sv | 112 +++++++++++
 1 files changed

// File: rtl/phy_tx_lane_serializer.sv
// Two-lane byte-striping serializer: 32-bit words go out MSB-first over 16-cycle frames,
// with IDLE_SYM filling empty frames. Define PHY_TX_STATS_EN to add the words_sent counter.
module phy_tx_lane_serializer #(
    parameter logic [7:0]  IDLE_SYM = 8'hBC
`ifdef PHY_TX_STATS_EN
    ,
    parameter int unsigned STATS_W  = 16
`endif
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic [31:0] Data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        Data_out_0,
    output logic        Data_out_1,
    output logic        active_out
`ifdef PHY_TX_STATS_EN
    ,
    output logic [STATS_W-1:0] words_sent
`endif
);

    typedef enum logic {StIdle, StData} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [7:0]  shift_0_q;
    logic [7:0]  shift_1_q;
    logic [7:0]  sec_0_q;
    logic [7:0]  sec_1_q;
    logic [31:0] hold_q;
    logic        hold_full_q;
    logic        ready_q;

    logic accept;
    logic boundary;
    logic mid_frame;

    assign accept    = valid_in && ready_q;
    assign boundary  = (cnt_q == 4'hF);
    assign mid_frame = (cnt_q == 4'h7);

    assign ready_out  = ready_q;
    assign Data_out_0 = shift_0_q[7];
    assign Data_out_1 = shift_1_q[7];
    assign active_out = (state_q == StData);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'hF;
            shift_0_q   <= 8'h00;
            shift_1_q   <= 8'h00;
            sec_0_q     <= 8'h00;
            sec_1_q     <= 8'h00;
            hold_q      <= 32'h0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            cnt_q <= cnt_q + 4'd1;

            // The frame type is only ever decided here, so frames are never partial.
            if (boundary) begin
                if (hold_full_q) begin
                    state_q   <= StData;
                    shift_0_q <= hold_q[31:24];
                    shift_1_q <= hold_q[23:16];
                    sec_0_q   <= hold_q[15:8];
                    sec_1_q   <= hold_q[7:0];
                end else begin
                    state_q   <= StIdle;
                    shift_0_q <= IDLE_SYM;
                    shift_1_q <= IDLE_SYM;
                    sec_0_q   <= IDLE_SYM;
                    sec_1_q   <= IDLE_SYM;
                end
            end else if (mid_frame) begin
                shift_0_q <= sec_0_q;
                shift_1_q <= sec_1_q;
            end else begin
                shift_0_q <= {shift_0_q[6:0], 1'b0};
                shift_1_q <= {shift_1_q[6:0], 1'b0};
            end

            // accept needs an empty holder, so it can never coincide with a transfer.
            if (accept) begin
                hold_q      <= Data_in;
                hold_full_q <= 1'b1;
                ready_q     <= 1'b0;
            end else if (boundary && hold_full_q) begin
                hold_full_q <= 1'b0;
                ready_q     <= 1'b1;
            end
        end
    end

`ifdef PHY_TX_STATS_EN
    logic [STATS_W-1:0] words_sent_q;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            words_sent_q <= '0;
        end else if (boundary && hold_full_q) begin
            words_sent_q <= words_sent_q + 1'b1;
        end
    end

    assign words_sent = words_sent_q;
`endif

endmodule
